// File: rtl/mul_fu.sv
// mul_fu: fixed-latency ARM64 MADD/MSUB/SMULH/UMULH unit with credit-limited in-order result buffer.
module mul_fu #(
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int LATENCY      = 3,
    parameter int OUT_DEPTH    = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   inst_valid,
    input  logic [INST_ID_BITS-1:0]                inst_id,
    input  logic [31:0]                            inst,
    input  logic [MAX_OPERANDS-1:0][63:0]          op,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  out_prn,
    input  logic [63:0]                            pc,
    output logic                                   fu_ready,
    output logic                                   wb_valid,
    output logic [INST_ID_BITS-1:0]                wb_inst_id,
    output logic [PRN_BITS-1:0]                    wb_prn,
    output logic [63:0]                            wb_value,
    output logic                                   wb_illegal,
    input  logic                                   wb_ack,
    output logic [MAX_OPERANDS-1:0]                set_prn_ready,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  set_prn,
    output logic                                   overflow_err
);
    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    typedef struct packed {
        logic [INST_ID_BITS-1:0] id;
        logic [PRN_BITS-1:0]     prn;
        logic [63:0]             val;
        logic                    ill;
    } res_t;

    logic           is_madd, is_smulh, is_umulh;
    logic [63:0]    addend, mac, res;
    logic [127:0]   sprod, uprod;
    res_t           in_e, push_e, head;
    logic           push, acc, pop;
    logic [CW-1:0]  occ_q, occ_d, cnt_q;
    logic [PW-1:0]  wp_q, rp_q;
    res_t           mem_q [OUT_DEPTH];
    logic           unused_ok;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        is_madd  = inst[30:21] == 10'b0011011000;
        is_smulh = inst[31:21] == 11'b10011011010;
        is_umulh = inst[31:21] == 11'b10011011110;
        addend   = (inst[14:10] == 5'd31) ? 64'd0 : op[2];
        mac      = inst[15] ? addend - op[0] * op[1] : addend + op[0] * op[1];
        sprod    = {{64{op[0][63]}}, op[0]} * {{64{op[1][63]}}, op[1]};
        uprod    = {64'd0, op[0]} * {64'd0, op[1]};
        res      = is_madd  ? (inst[31] ? mac : {32'd0, mac[31:0]}) :
                   is_smulh ? sprod[127:64] :
                   is_umulh ? uprod[127:64] : 64'd0;
        in_e     = '{id: inst_id, prn: out_prn[0], val: res, ill: !(is_madd || is_smulh || is_umulh)};
    end

    // Result is computed at issue and then delayed so the FIFO push lands at t+LATENCY-1.
    generate
        if (LATENCY == 1) begin : g_direct
            assign push   = acc;
            assign push_e = in_e;
        end else begin : g_pipe
            res_t                stg_q [LATENCY-1];
            logic [LATENCY-2:0]  vld_q;
            always_ff @(posedge clk) begin
                if (rst) vld_q <= '0;
                else begin
                    vld_q[0] <= acc;
                    for (int k = 1; k < LATENCY - 1; k++) vld_q[k] <= vld_q[k-1];
                end
            end
            always_ff @(posedge clk) begin
                stg_q[0] <= in_e;
                for (int k = 1; k < LATENCY - 1; k++) stg_q[k] <= stg_q[k-1];
            end
            assign push   = vld_q[LATENCY-2];
            assign push_e = stg_q[LATENCY-2];
        end
    endgenerate

    always_comb begin
        acc           = inst_valid && !rst && (occ_q < CW'(OUT_DEPTH));
        wb_valid      = cnt_q != '0;
        pop           = wb_valid && wb_ack && !rst;
        occ_d         = occ_q + CW'(acc) - CW'(pop);
        fu_ready      = !rst && (({1'b0, occ_q} + (CW+1)'(inst_valid)) < (CW+1)'(OUT_DEPTH));
        head          = wb_valid ? mem_q[rp_q] : '0;
        wb_inst_id    = head.id;
        wb_prn        = head.prn;
        wb_value      = head.val;
        wb_illegal    = head.ill;
        set_prn_ready = {MAX_OPERANDS{pop}};
        set_prn       = pop ? {MAX_OPERANDS{head.prn}} : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q        <= '0;
            cnt_q        <= '0;
            wp_q         <= '0;
            rp_q         <= '0;
            overflow_err <= 1'b0;
        end else begin
            occ_q <= occ_d;
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
            if (push) wp_q <= nxt(wp_q);
            if (pop) rp_q <= nxt(rp_q);
            if (inst_valid && occ_q == CW'(OUT_DEPTH)) overflow_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= push_e;
    end

    assign unused_ok = ^{pc, inst[20:16], inst[9:0], out_prn[MAX_OPERANDS-1:1], sprod[63:0], uprod[63:0]};
endmodule

// File: tb/tb_mul_fu.sv
// tb_mul_fu: directed vectors for mul_fu with a queue scoreboard checked by an independent monitor.
module tb_mul_fu;
    localparam int LAT = 3;

    typedef struct packed {
        logic [5:0]  id;
        logic [5:0]  prn;
        logic [63:0] val;
        logic        ill;
    } exp_t;

    logic             clk = 0, rst = 1, inst_valid = 0, wb_ack = 0;
    logic [5:0]       inst_id = 0;
    logic [31:0]      inst = 0;
    logic [2:0][63:0] op = '0;
    logic [2:0][5:0]  out_prn = '0;
    logic [63:0]      pc = 0;
    logic             fu_ready, wb_valid, wb_illegal, overflow_err;
    logic [5:0]       wb_inst_id, wb_prn;
    logic [63:0]      wb_value;
    logic [2:0]       set_prn_ready;
    logic [2:0][5:0]  set_prn;

    exp_t q[$];
    int   chk_cnt = 0, pass_cnt = 0;
    logic [5:0] nid = 1;

    mul_fu dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_id(inst_id), .inst(inst),
        .op(op), .out_prn(out_prn), .pc(pc), .fu_ready(fu_ready), .wb_valid(wb_valid),
        .wb_inst_id(wb_inst_id), .wb_prn(wb_prn), .wb_value(wb_value), .wb_illegal(wb_illegal),
        .wb_ack(wb_ack), .set_prn_ready(set_prn_ready), .set_prn(set_prn), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string n, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%h exp=%h", n, got, exp);
    endtask

    task automatic issue(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c, input logic [63:0] v, input logic ill, input bit accept);
        inst_valid = 1; inst = i; op[0] = a; op[1] = b; op[2] = c;
        inst_id = nid; out_prn[0] = nid ^ 6'h2A; out_prn[1] = 6'h11; out_prn[2] = 6'h22;
        pc = {32'h0, 26'h0, nid} << 2;
        if (accept) q.push_back('{id: nid, prn: nid ^ 6'h2A, val: v, ill: ill});
        nid = nid + 1;
        @(posedge clk); #1;
        inst_valid = 0;
    endtask

    task automatic lat_check();
        int k;
        k = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (wb_valid) begin k = n; break; end
        end
        check("latency", k, LAT);
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 100 && q.size() != 0; n++) @(negedge clk);
        #1;
        check("drain", q.size(), 0);
    endtask

    always @(negedge clk) begin
        bit   b;
        exp_t e;
        b = wb_valid && wb_ack && !rst;
        check("bcast_ready", 64'(set_prn_ready), b ? 64'h7 : 64'h0);
        if (b) begin
            if (q.size() == 0) check("extra_wb", 1, 0);
            else begin
                e = q.pop_front();
                check("wb_id", wb_inst_id, e.id);
                check("wb_prn", wb_prn, e.prn);
                check("wb_value", wb_value, e.val);
                check("wb_illegal", wb_illegal, e.ill);
                check("bcast_prn", 64'(set_prn), 64'({3{e.prn}}));
            end
        end else check("bcast_prn_idle", 64'(set_prn), 0);
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        bit stray;
        repeat (3) @(posedge clk);
        #1;
        check("rst_fu_ready", fu_ready, 0);
        rst = 0;
        @(negedge clk);
        check("post_rst_fu_ready", fu_ready, 1);
        check("post_rst_wb_valid", wb_valid, 0);
        check("post_rst_ovf", overflow_err, 0);
        check("post_rst_value", wb_value, 0);

        wb_ack = 1;
        issue(32'h9B000400, 3, 5, 7, 22, 0, 1);
        lat_check();
        wait_drain();

        issue(32'h9B008400, 3, 5, 7, 64'hFFFF_FFFF_FFFF_FFF8, 0, 1);
        issue(32'h9B007C00, 3, 5, 99, 15, 0, 1);
        issue(32'h1B007C00, 64'hFFFF_FFFF, 2, 64'h55, 64'h0000_0000_FFFF_FFFE, 0, 1);
        issue(32'h9BC00000, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0, 1, 0, 1);
        issue(32'h9B400000, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1);
        issue(32'h0000_0000, 3, 5, 7, 0, 1, 1);
        wait_drain();

        wb_ack = 0;
        issue(32'h9B000400, 1, 2, 3, 5, 0, 1);
        issue(32'h9B000400, 4, 5, 6, 26, 0, 1);
        issue(32'h9B000400, 10, 10, 0, 100, 0, 1);
        issue(32'h9B000400, 64'h1_0000_0000, 64'h1_0000_0000, 1, 1, 0, 1);
        @(negedge clk);
        check("full_fu_ready", fu_ready, 0);
        issue(32'h9B000400, 9, 9, 9, 90, 0, 0);
        @(negedge clk);
        check("ovf_set", overflow_err, 1);
        repeat (3) @(negedge clk);
        check("ovf_sticky", overflow_err, 1);
        check("full_wb_valid", wb_valid, 1);
        check("full_head", wb_value, 5);
        @(posedge clk); #1;
        wb_ack = 1;
        @(negedge clk); #1;
        check("drain1", q.size(), 3);
        @(negedge clk); #1;
        check("ready_back", fu_ready, 1);
        repeat (2) @(negedge clk);
        #1;
        check("drain_4cyc", q.size(), 0);
        repeat (3) @(negedge clk);
        check("no_extra_wb", wb_valid, 0);

        wb_ack = 0;
        issue(32'h9B007C00, 2, 3, 0, 6, 0, 1);
        issue(32'h9B007C00, 4, 3, 0, 12, 0, 1);
        issue(32'h9B007C00, 5, 3, 0, 15, 0, 1);
        issue(32'h9B007C00, 6, 3, 0, 18, 0, 1);
        rst = 1; wb_ack = 1;
        @(negedge clk);
        check("rst2_fu_ready", fu_ready, 0);
        @(posedge clk); #1;
        rst = 0;
        q.delete();
        @(negedge clk);
        check("rst2_wb_valid", wb_valid, 0);
        check("rst2_value", wb_value, 0);
        check("rst2_prn", wb_prn, 0);
        check("rst2_id", wb_inst_id, 0);
        check("rst2_ill", wb_illegal, 0);
        check("rst2_ovf", overflow_err, 0);
        check("rst2_fu_ready_up", fu_ready, 1);
        stray = 0;
        repeat (5) begin
            @(negedge clk);
            if (wb_valid) stray = 1;
        end
        check("rst2_no_stray", stray, 0);
        issue(32'h9B000400, 3, 5, 7, 22, 0, 1);
        lat_check();
        wait_drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
